// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   CPU register file with two combinational read ports, one synchronous
//   write port, a per-register busy scoreboard and a registered busy count.
//   Decode reads operands and marks destinations busy on issue; writeback
//   writes results and clears the matching busy bit.
//
// Parameters
//   DATA_WIDTH  width of each register and of the data ports
//   ADDR_WIDTH  address width; depth = 2**ADDR_WIDTH
//   ZERO_REG    1 = entry 0 reads as 0; writes and issues to it are ignored
//   BYPASS      1 = a same-cycle write is forwarded to matching read ports
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous reset, active-high; overrides write and issue
//   write        write enable for the writeback port
//   write_addr   destination register of the write
//   write_data   data to write
//   read_addr1   read port 1 address
//   read_data1   read port 1 data (combinational)
//   read_busy1   read port 1 target has a pending producer
//   read_addr2   read port 2 address
//   read_data2   read port 2 data (combinational)
//   read_busy2   read port 2 target has a pending producer
//   issue        mark issue_addr busy
//   issue_addr   destination register being issued
//   busy_count   registered popcount of the busy bits
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic                  read_busy1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic                  read_busy2,
    input  logic                  issue,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  busy;
    } read_t;

    logic [DATA_WIDTH-1:0] entry_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [CW-1:0]         busy_count_q;
    logic [CW-1:0]         busy_count_d;

    logic write_en;
    logic issue_en;
    read_t port1;
    read_t port2;

    // Entry 0 is immune to writes and issues when it is the hardwired zero;
    // gating here keeps its stored value and busy bit at their reset value.
    assign write_en = write && !(ZERO_REG && (write_addr == '0));
    assign issue_en = issue && !(ZERO_REG && (issue_addr == '0));

    // Scoreboard next state. Issue beats write so that a new producer
    // dispatched in the same cycle as the old one retires keeps the entry busy.
    // NOTE: combinational blocks use blocking assignments and assign every
    // output a default first, so no latch can be inferred.
    always_comb begin
        busy_d = busy_q;
        for (int n = 0; n < DEPTH; n++) begin
            if (rst) begin
                busy_d[n] = 1'b0;
            end else if (issue_en && (issue_addr == ADDR_WIDTH'(n))) begin
                busy_d[n] = 1'b1;
            end else if (write_en && (write_addr == ADDR_WIDTH'(n))) begin
                busy_d[n] = 1'b0;
            end
        end
    end

    // The count is computed from the next busy vector so the registered
    // value always matches the busy bits that land on the same edge.
    always_comb begin
        busy_count_d = '0;
        for (int n = 0; n < DEPTH; n++) begin
            busy_count_d = busy_count_d + CW'(busy_d[n]);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values regardless of block order.
    // NOTE: the storage array is reset entry by entry, which forces it into
    // flops; a RAM macro could not offer a single-cycle clear of all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < DEPTH; n++) begin
                entry_q[n] <= '0;
            end
        end else if (write_en) begin
            entry_q[write_addr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        busy_q       <= busy_d;
        busy_count_q <= busy_count_d;
    end

    // Read resolution for one port: hardwired zero, then same-cycle write
    // bypass (suppressed while rst is high), then stored contents.
    function automatic read_t resolve(input logic [ADDR_WIDTH-1:0] addr);
        read_t r;
        if (ZERO_REG && (addr == '0)) begin
            r.data = '0;
            r.busy = 1'b0;
        end else if (BYPASS && write && !rst && (write_addr == addr)) begin
            // The in-flight result resolves the hazard, so busy reads clear.
            r.data = write_data;
            r.busy = 1'b0;
        end else begin
            r.data = entry_q[addr];
            r.busy = busy_q[addr];
        end
        return r;
    endfunction

    always_comb begin
        port1 = resolve(read_addr1);
        port2 = resolve(read_addr2);
    end

    assign read_data1 = port1.data;
    assign read_busy1 = port1.busy;
    assign read_data2 = port2.data;
    assign read_busy2 = port2.busy;
    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//   Directed scenarios plus randomized traffic for regfile_sb. The default
//   configuration is checked against an array/bit-vector model of the
//   register file; a second, narrow instance without bypass and without the
//   zero register is checked with directed constants.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: DATA_WIDTH=32, ADDR_WIDTH=5, ZERO_REG=1, BYPASS=1
    logic        rst;
    logic        write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr1;
    logic [31:0] read_data1;
    logic        read_busy1;
    logic [4:0]  read_addr2;
    logic [31:0] read_data2;
    logic        read_busy2;
    logic        issue;
    logic [4:0]  issue_addr;
    logic [5:0]  busy_count;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .write      (write),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr1 (read_addr1),
        .read_data1 (read_data1),
        .read_busy1 (read_busy1),
        .read_addr2 (read_addr2),
        .read_data2 (read_data2),
        .read_busy2 (read_busy2),
        .issue      (issue),
        .issue_addr (issue_addr),
        .busy_count (busy_count)
    );

    // Narrow instance: DATA_WIDTH=16, ADDR_WIDTH=3, ZERO_REG=0, BYPASS=0
    logic        n_rst;
    logic        n_write;
    logic [2:0]  n_write_addr;
    logic [15:0] n_write_data;
    logic [2:0]  n_read_addr1;
    logic [15:0] n_read_data1;
    logic        n_read_busy1;
    logic [2:0]  n_read_addr2;
    logic [15:0] n_read_data2;
    logic        n_read_busy2;
    logic        n_issue;
    logic [2:0]  n_issue_addr;
    logic [3:0]  n_busy_count;

    regfile_sb #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (3),
        .ZERO_REG   (1'b0),
        .BYPASS     (1'b0)
    ) dut_nb (
        .clk        (clk),
        .rst        (n_rst),
        .write      (n_write),
        .write_addr (n_write_addr),
        .write_data (n_write_data),
        .read_addr1 (n_read_addr1),
        .read_data1 (n_read_data1),
        .read_busy1 (n_read_busy1),
        .read_addr2 (n_read_addr2),
        .read_data2 (n_read_data2),
        .read_busy2 (n_read_busy2),
        .issue      (n_issue),
        .issue_addr (n_issue_addr),
        .busy_count (n_busy_count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model of the default instance
    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    // Expected read result from the current model state and current inputs.
    function automatic void m_read(input logic [4:0] a, output logic [31:0] d,
                                   output logic b);
        if (a == 5'd0) begin
            d = 32'd0; b = 1'b0;
        end else if (write && !rst && write_addr == a) begin
            d = write_data; b = 1'b0;
        end else begin
            d = m_mem[a]; b = m_busy[a];
        end
    endfunction

    // Advance one rising edge and apply the same inputs to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 32'd0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (issue && issue_addr != 5'd0) begin
                m_busy[issue_addr] = 1'b1;
                if (write && write_addr != 5'd0 && write_addr != issue_addr)
                    m_busy[write_addr] = 1'b0;
            end else if (write && write_addr != 5'd0) begin
                m_busy[write_addr] = 1'b0;
            end
            if (write && write_addr != 5'd0) m_mem[write_addr] = write_data;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; write = 1'b0; issue = 1'b0;
        write_addr = '0; write_data = '0; issue_addr = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] a;
        do_reset();
        checks++;
        if (busy_count !== 6'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d want=0", busy_count);
        end
        for (int i = 0; i < 4; i++) begin
            a = 5'($urandom_range(0, 31));
            read_addr1 = a; read_addr2 = 5'(31 - i);
            @(negedge clk);
            checks++;
            if (read_data1 !== 32'd0 || read_busy1 !== 1'b0 ||
                read_data2 !== 32'd0 || read_busy2 !== 1'b0) begin
                failures++;
                $display("FAIL reset_read a=%0d got=%h/%b %h/%b want=0/0", a,
                         read_data1, read_busy1, read_data2, read_busy2);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        do_reset();
        issue = 1'b1; issue_addr = 5'd3;
        tick();
        idle();
        read_addr1 = 5'd3;
        @(negedge clk);
        checks++;
        if (busy_count !== 6'd1 || read_busy1 !== 1'b1) begin
            failures++;
            $display("FAIL issue_busy got count=%0d busy=%b want 1/1",
                     busy_count, read_busy1);
        end
        write = 1'b1; write_addr = 5'd3; write_data = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'hDEADBEEF || read_busy1 !== 1'b0) begin
            failures++;
            $display("FAIL bypass got=%h/%b want=deadbeef/0", read_data1, read_busy1);
        end
        tick();
        idle();
        checks++;
        if (busy_count !== 6'd0 || read_data1 !== 32'hDEADBEEF || read_busy1 !== 1'b0) begin
            failures++;
            $display("FAIL after_write got count=%0d data=%h busy=%b want 0/deadbeef/0",
                     busy_count, read_data1, read_busy1);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        write = 1'b1; write_addr = 5'd0; write_data = 32'h1234;
        issue = 1'b1; issue_addr = 5'd0;
        read_addr2 = 5'd0;
        @(negedge clk);
        checks++;
        if (read_data2 !== 32'd0 || read_busy2 !== 1'b0) begin
            failures++;
            $display("FAIL zero_bypass got=%h/%b want=0/0", read_data2, read_busy2);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (read_data2 !== 32'd0 || read_busy2 !== 1'b0 || busy_count !== 6'd0) begin
            failures++;
            $display("FAIL zero_after got=%h/%b count=%0d want=0/0/0",
                     read_data2, read_busy2, busy_count);
        end
    endtask

    task automatic test_issue_write_same();
        do_reset();
        issue = 1'b1; issue_addr = 5'd5;
        write = 1'b1; write_addr = 5'd5; write_data = 32'd7;
        tick();
        idle();
        read_addr1 = 5'd5;
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'd7 || read_busy1 !== 1'b1 || busy_count !== 6'd1) begin
            failures++;
            $display("FAIL issue_write_same got=%h/%b count=%0d want=7/1/1",
                     read_data1, read_busy1, busy_count);
        end
    endtask

    task automatic test_multi_issue();
        logic [4:0]  seq [4];
        int          want [4];
        logic [31:0] d;
        seq  = '{5'd1, 5'd2, 5'd2, 5'd3};
        want = '{1, 2, 2, 3};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue = 1'b1; issue_addr = seq[i];
            tick();
            checks++;
            if (busy_count !== 6'(want[i])) begin
                failures++;
                $display("FAIL multi_issue step=%0d got=%0d want=%0d",
                         i, busy_count, want[i]);
            end
        end
        idle();
        d = $urandom;
        write = 1'b1; write_addr = 5'd9; write_data = d;
        tick();
        idle();
        read_addr1 = 5'd9; read_addr2 = 5'd2;
        @(negedge clk);
        checks++;
        if (busy_count !== 6'd3 || read_data1 !== d || read_busy1 !== 1'b0 ||
            read_busy2 !== 1'b1) begin
            failures++;
            $display("FAIL write_not_busy got count=%0d data=%h busy9=%b busy2=%b want 3/%h/0/1",
                     busy_count, read_data1, read_busy1, read_busy2, d);
        end
    endtask

    task automatic test_reset_override();
        do_reset();
        for (int i = 1; i < 32; i++) begin
            write = 1'b1; write_addr = 5'(i); write_data = 32'(i);
            tick();
        end
        idle();
        issue = 1'b1; issue_addr = 5'd4;
        tick();
        rst = 1'b1;
        write = 1'b1; write_addr = 5'd6; write_data = 32'hFF;
        issue = 1'b1; issue_addr = 5'd7;
        read_addr1 = 5'd6; read_addr2 = 5'd4;
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'd6 || read_busy1 !== 1'b0 ||
            read_data2 !== 32'd4 || read_busy2 !== 1'b1) begin
            failures++;
            $display("FAIL rst_cycle_read got=%h/%b %h/%b want=6/0 4/1",
                     read_data1, read_busy1, read_data2, read_busy2);
        end
        tick();
        idle();
        checks++;
        if (busy_count !== 6'd0) begin
            failures++;
            $display("FAIL rst_override_count got=%0d want=0", busy_count);
        end
        for (int i = 0; i < 32; i += 2) begin
            read_addr1 = 5'(i); read_addr2 = 5'(i + 1);
            #1;
            checks++;
            if (read_data1 !== 32'd0 || read_busy1 !== 1'b0 ||
                read_data2 !== 32'd0 || read_busy2 !== 1'b0) begin
                failures++;
                $display("FAIL rst_clear a=%0d got=%h/%b %h/%b want=0/0", i,
                         read_data1, read_busy1, read_data2, read_busy2);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d1, d2;
        logic        b1, b2;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 63) == 0);
            write = $urandom_range(0, 1) == 1;
            issue = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 1) == 1) begin
                write_addr = 5'($urandom_range(0, 3));
                issue_addr = 5'($urandom_range(0, 3));
                read_addr1 = 5'($urandom_range(0, 3));
                read_addr2 = 5'($urandom_range(0, 3));
            end else begin
                write_addr = 5'($urandom);
                issue_addr = 5'($urandom);
                read_addr1 = 5'($urandom);
                read_addr2 = 5'($urandom);
            end
            write_data = $urandom;
            @(negedge clk);
            m_read(read_addr1, d1, b1);
            m_read(read_addr2, d2, b2);
            checks++;
            if (read_data1 !== d1 || read_busy1 !== b1 ||
                read_data2 !== d2 || read_busy2 !== b2) begin
                failures++;
                $display("FAIL rand_read cyc=%0d a1=%0d got=%h/%b want=%h/%b a2=%0d got=%h/%b want=%h/%b",
                         c, read_addr1, read_data1, read_busy1, d1, b1,
                         read_addr2, read_data2, read_busy2, d2, b2);
            end
            tick();
            checks++;
            if (busy_count !== 6'(m_count())) begin
                failures++;
                $display("FAIL rand_count cyc=%0d got=%0d want=%0d",
                         c, busy_count, m_count());
            end
        end
        idle();
    endtask

    task automatic test_no_bypass();
        logic [15:0] vals [8];
        n_rst = 1'b1; n_write = 1'b0; n_issue = 1'b0;
        n_write_addr = '0; n_write_data = '0; n_issue_addr = '0;
        n_read_addr1 = '0; n_read_addr2 = '0;
        tick();
        n_rst = 1'b0;
        checks++;
        if (n_busy_count !== 4'd0) begin
            failures++;
            $display("FAIL nb_reset_count got=%0d want=0", n_busy_count);
        end
        n_write = 1'b1; n_write_addr = 3'd2; n_write_data = 16'h1111;
        n_issue = 1'b1; n_issue_addr = 3'd2;
        tick();
        n_issue = 1'b0;
        n_write_data = 16'hABCD;
        n_read_addr1 = 3'd2;
        @(negedge clk);
        checks++;
        if (n_read_data1 !== 16'h1111 || n_read_busy1 !== 1'b1) begin
            failures++;
            $display("FAIL nb_same_cycle got=%h/%b want=1111/1", n_read_data1, n_read_busy1);
        end
        tick();
        n_write = 1'b0;
        #1;
        checks++;
        if (n_read_data1 !== 16'hABCD || n_read_busy1 !== 1'b0 || n_busy_count !== 4'd0) begin
            failures++;
            $display("FAIL nb_next_cycle got=%h/%b count=%0d want=abcd/0/0",
                     n_read_data1, n_read_busy1, n_busy_count);
        end
        // Fill every entry, including 0, with distinct values: no aliasing.
        for (int i = 0; i < 8; i++) begin
            vals[i] = 16'($urandom);
            n_write = 1'b1; n_write_addr = 3'(i); n_write_data = vals[i];
            tick();
        end
        n_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_read_addr1 = 3'(i); n_read_addr2 = 3'(7 - i);
            #1;
            checks++;
            if (n_read_data1 !== vals[i] || n_read_data2 !== vals[7 - i]) begin
                failures++;
                $display("FAIL nb_fill a=%0d got=%h/%h want=%h/%h", i,
                         n_read_data1, n_read_data2, vals[i], vals[7 - i]);
            end
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        read_addr1 = '0; read_addr2 = '0;
        n_rst = 1'b1; n_write = 1'b0; n_issue = 1'b0;
        n_write_addr = '0; n_write_data = '0; n_issue_addr = '0;
        n_read_addr1 = '0; n_read_addr2 = '0;
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'd0; m_busy[i] = 1'b0;
        end
        test_reset();
        test_bypass();
        test_zero_reg();
        test_issue_write_same();
        test_multi_issue();
        test_reset_override();
        test_random();
        test_no_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
